idi_source: RTL and testbench
=============================

# idi_source

Initiator for the IDI request interface: accepts one command at a time on a host-side command port, drives it onto the `valid`/`ready` IDI bus toward `idi_sink`, captures read data, and returns a response on a host-side response port. It is the request-generating end of the link. Testbenches and future host logic use it to talk to the sink. A watchdog aborts requests the sink never accepts.

## Interface
Parameters:
- `TIMEOUT`, default 64: max cycles in REQ waiting for `ready`; 0 disables the watchdog.
- `CNT_W`, default 16: width of `txn_count`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_is_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  64  request address.
- `cmd_wdata`  in  32  write data (ignored for reads).
- `valid`  out  1  IDI request valid.
- `ready`  in  1  IDI sink accepts request.
- `is_write`  out  1  IDI request type.
- `addr`  out  64  IDI address.
- `wdata`  out  32  IDI write data.
- `rdata`  in  32  IDI read data; valid in the transfer cycle.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host consumes response.
- `rsp_is_write`  out  1  type of completed request.
- `rsp_rdata`  out  32  captured read data; 0 for writes and errors.
- `rsp_err`  out  1  request aborted by watchdog.
- `txn_count`  out  CNT_W  number of successful IDI transfers, wraps.

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_is_write`/`cmd_addr`/`cmd_wdata` into request registers, clear wait counter, go REQ.
- REQ: `valid`=1; `is_write`/`addr`/`wdata` driven from the registers and held stable until the request leaves REQ.
  - On `valid && ready`: transfer. Latch `rdata` into `rsp_rdata` if read, else 0. Set `rsp_err`=0. Increment `txn_count`. Go RSP.
  - Else increment the wait counter. If `TIMEOUT`≠0 and this is the TIMEOUT-th REQ cycle without `ready`: `rsp_rdata`=0, `rsp_err`=1, `txn_count` unchanged, go RSP.
  - `ready` asserted in the same cycle the watchdog expires: the transfer wins and `rsp_err`=0.
- RSP: `rsp_valid`=1; `rsp_*` held stable. On `rsp_ready`, go IDLE. No new command is accepted in RSP.
- `ready` while not in REQ is ignored; `rdata` is only sampled in the transfer cycle.
- `txn_count` wraps from 2^CNT_W−1 to 0 with no flag.
- Outputs are registered or decoded from state only; no combinational path from `ready` or `rsp_ready` to any output.

## Timing
- Reset values: state=IDLE, `cmd_ready`=1, `valid`=0, `is_write`=0, `addr`=0, `wdata`=0, `rsp_valid`=0, `rsp_is_write`=0, `rsp_rdata`=0, `rsp_err`=0, `txn_count`=0.
- `rst` asserted in any state takes effect at the next edge and overrides all other inputs. An in-flight request is dropped with no response, and `valid` is 0 the cycle after.
- Command accepted at edge N: `valid`=1 from cycle N+1.
- `ready` high in cycle N+1: `rsp_valid`=1 in cycle N+2.
- `rsp_ready` high in cycle N+2: `cmd_ready`=1 in cycle N+3.
- Minimum 3 cycles per transaction; one transaction outstanding at most.
- Watchdog: with `ready` held low, `valid` is high for exactly TIMEOUT cycles, then `rsp_valid`=1 with `rsp_err`=1 the next cycle.

## Test plan
- Write: cmd write, addr 0x100, wdata 0xDEADBEEF; sink `ready` in the first REQ cycle. Required: bus shows valid=1, is_write=1, addr=0x100, wdata=0xDEADBEEF for 1 cycle. Then rsp_valid=1, rsp_is_write=1, rsp_rdata=0, rsp_err=0, txn_count=1.
- Read: cmd read, addr 0x100; sink returns 0xDEADBEEF with `ready` after 3 wait cycles. Required: valid held for 4 cycles with stable addr; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Timeout: TIMEOUT=4, `ready` tied 0, read addr 0x200. Required: valid high exactly 4 cycles; rsp_err=1, rsp_rdata=0, txn_count unchanged.
- Timeout tie: TIMEOUT=4, `ready` first asserted in the 4th REQ cycle. Required: normal completion with rsp_err=0 and txn_count incremented.
- Response backpressure: hold `rsp_ready`=0 for 5 cycles after completion. Required: rsp fields stable, cmd_ready=0, and a new cmd_valid is not accepted until the cycle after rsp_ready.
- Reset mid-REQ: assert `rst` for 1 cycle in the 2nd REQ cycle. Required: next cycle valid=0, cmd_ready=1, rsp_valid=0, txn_count=0. A subsequent write completes normally.

Source files
------------

// File: rtl/idi_source.sv
`default_nettype none
// ============================================================================
// Module      : idi_source
// Description : IDI request initiator. Takes one host command at a time,
//               presents it on the valid/ready bus, and returns a response
//               carrying read data or a watchdog error.
// Revision    : 1.0 - initial release
// ============================================================================
module idi_source #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_is_write,
    input  logic [63:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,

    output logic             valid,
    input  logic             ready,
    output logic             is_write,
    output logic [63:0]      addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_is_write,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1: the expiring cycle is
    // detected by comparison rather than by counting one further.
    localparam int                  c_WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                  c_WDOG_EN   = (TIMEOUT != 0);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_is_write;
    logic [63:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic                r_rsp_is_write;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_txn_count;

    logic                w_accept;
    logic                w_xfer;
    logic                w_expire;

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_xfer   = (r_state == ST_REQ) && ready;
    // A transfer in the expiring cycle takes priority, hence the !ready term.
    assign w_expire = c_WDOG_EN && (r_state == ST_REQ) && !ready
                      && (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        valid       = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                valid = 1'b1;
                if (w_xfer || w_expire) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_write     <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_wait_cnt     <= '0;
            r_rsp_is_write <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
            r_txn_count    <= '0;
        end else begin
            if (w_accept) begin
                r_is_write <= cmd_is_write;
                r_addr     <= cmd_addr;
                r_wdata    <= cmd_wdata;
                r_wait_cnt <= '0;
            end else if ((r_state == ST_REQ) && !ready) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end

            if (w_xfer) begin
                r_rsp_is_write <= r_is_write;
                r_rsp_rdata    <= r_is_write ? 32'h0 : rdata;
                r_rsp_err      <= 1'b0;
                r_txn_count    <= r_txn_count + CNT_W'(1);
            end else if (w_expire) begin
                r_rsp_is_write <= r_is_write;
                r_rsp_rdata    <= 32'h0;
                r_rsp_err      <= 1'b1;
            end
        end
    end

    assign is_write     = r_is_write;
    assign addr         = r_addr;
    assign wdata        = r_wdata;
    assign rsp_is_write = r_rsp_is_write;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign txn_count    = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_idi_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_idi_source
// Description : Self-checking bench for idi_source: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idi_source;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_is_write;
    logic [63:0]      cmd_addr;
    logic [31:0]      cmd_wdata;
    logic             valid;
    logic             ready;
    logic             is_write;
    logic [63:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_is_write;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [CNT_W-1:0] txn_count;

    always #5 clk = ~clk;

    idi_source #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .valid(valid), .ready(ready), .is_write(is_write), .addr(addr),
        .wdata(wdata), .rdata(rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .txn_count(txn_count)
    );

    int checks = 0;
    int errors = 0;
    int vcnt;

    // Transaction-level view: one request in flight, one response pending.
    bit          m_req_busy;
    bit          m_rsp_busy;
    int          m_age;
    logic        m_is_write;
    logic [63:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rsp_is_write;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;
    int          m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_req_busy = 0; m_rsp_busy = 0; m_age = 0;
            m_is_write = 0; m_addr = 0; m_wdata = 0;
            m_rsp_is_write = 0; m_rsp_rdata = 0; m_rsp_err = 0; m_count = 0;
        end else if (m_req_busy) begin
            if (ready) begin
                m_rsp_is_write = m_is_write;
                m_rsp_rdata    = m_is_write ? 32'h0 : rdata;
                m_rsp_err      = 0;
                m_count        = (m_count + 1) % (1 << CNT_W);
                m_req_busy = 0; m_rsp_busy = 1;
            end else begin
                m_age++;
                if (TIMEOUT != 0 && m_age == TIMEOUT) begin
                    m_rsp_is_write = m_is_write;
                    m_rsp_rdata    = 32'h0;
                    m_rsp_err      = 1;
                    m_req_busy = 0; m_rsp_busy = 1;
                end
            end
        end else if (m_rsp_busy) begin
            if (rsp_ready) m_rsp_busy = 0;
        end else if (cmd_valid) begin
            m_is_write = cmd_is_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
            m_age = 0; m_req_busy = 1;
        end
    endtask

    task automatic compare_all();
        chk("cmd_ready", 64'(cmd_ready), 64'(!m_req_busy && !m_rsp_busy));
        chk("valid", 64'(valid), 64'(m_req_busy));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_busy));
        chk("txn_count", 64'(txn_count), 64'(m_count));
        if (m_req_busy) begin
            chk("is_write", 64'(is_write), 64'(m_is_write));
            chk("addr", addr, m_addr);
            chk("wdata", 64'(wdata), 64'(m_wdata));
        end
        if (m_rsp_busy) begin
            chk("rsp_is_write", 64'(rsp_is_write), 64'(m_rsp_is_write));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_rdata));
            chk("rsp_err", 64'(rsp_err), 64'(m_rsp_err));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        if (valid) vcnt++;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [63:0] a, input logic [31:0] d);
        cmd_valid = v; cmd_is_write = w; cmd_addr = a; cmd_wdata = d;
    endtask

    initial begin
        rst = 1; ready = 0; rdata = 0; rsp_ready = 0;
        set_cmd(0, 0, 0, 0);
        step(); step();
        chk("reset cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset addr", addr, 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset txn_count", 64'(txn_count), 64'd0);
        rst = 0;

        // Write, ready in the first REQ cycle
        set_cmd(1, 1, 64'h100, 32'hDEADBEEF); ready = 1; vcnt = 0;
        step();
        chk("wr bus valid", 64'(valid), 64'd1);
        chk("wr bus addr", addr, 64'h100);
        chk("wr bus wdata", 64'(wdata), 64'hDEADBEEF);
        set_cmd(0, 0, 0, 0);
        step();
        chk("wr valid cycles", 64'(vcnt), 64'd1);
        chk("wr rsp_is_write", 64'(rsp_is_write), 64'd1);
        chk("wr rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("wr rsp_err", 64'(rsp_err), 64'd0);
        chk("wr txn_count", 64'(txn_count), 64'd1);
        rsp_ready = 1; ready = 0;
        step();
        rsp_ready = 0;

        // Read, three wait cycles; rdata garbage until the transfer cycle
        set_cmd(1, 0, 64'h100, 32'h0); vcnt = 0; rdata = 32'h12345678;
        step();
        set_cmd(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        ready = 1; rdata = 32'hDEADBEEF;
        step();
        ready = 0; rdata = 32'h0;
        chk("rd valid cycles", 64'(vcnt), 64'd4);
        chk("rd rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd rsp_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1; step(); rsp_ready = 0;

        // Timeout with ready tied low
        set_cmd(1, 0, 64'h200, 32'h0); vcnt = 0;
        step();
        set_cmd(0, 0, 0, 0);
        for (int i = 0; i < 20 && !rsp_valid; i++) step();
        chk("to rsp_valid", 64'(rsp_valid), 64'd1);
        chk("to valid cycles", 64'(vcnt), 64'd4);
        chk("to rsp_err", 64'(rsp_err), 64'd1);
        chk("to rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("to txn_count", 64'(txn_count), 64'd2);
        rsp_ready = 1; step(); rsp_ready = 0;

        // Ready first seen in the expiring cycle
        set_cmd(1, 0, 64'h300, 32'h0);
        step();
        set_cmd(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();
        ready = 1; rdata = 32'hCAFE0001;
        step();
        ready = 0;
        chk("tie rsp_err", 64'(rsp_err), 64'd0);
        chk("tie rsp_rdata", 64'(rsp_rdata), 64'hCAFE0001);
        chk("tie txn_count", 64'(txn_count), 64'd3);

        // Response backpressure with a waiting command
        set_cmd(1, 1, 64'h400, 32'h55AA55AA);
        for (int i = 0; i < 5; i++) step();
        chk("bp cmd_ready", 64'(cmd_ready), 64'd0);
        chk("bp rsp_rdata", 64'(rsp_rdata), 64'hCAFE0001);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("bp valid after rsp_ready", 64'(valid), 64'd0);
        step();
        chk("bp accepted next", 64'(valid), 64'd1);
        set_cmd(0, 0, 0, 0); ready = 1;
        step();
        ready = 0; rsp_ready = 1;
        step();
        rsp_ready = 0;

        // Reset during the second REQ cycle
        set_cmd(1, 1, 64'h500, 32'h11112222);
        step();
        set_cmd(0, 0, 0, 0);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rst valid", 64'(valid), 64'd0);
        chk("rst cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst txn_count", 64'(txn_count), 64'd0);
        set_cmd(1, 1, 64'h600, 32'h33334444); ready = 1;
        step();
        set_cmd(0, 0, 0, 0);
        step();
        chk("post rst rsp_err", 64'(rsp_err), 64'd0);
        chk("post rst txn_count", 64'(txn_count), 64'd1);
        rsp_ready = 1; step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 149) == 0);
            cmd_valid    = $urandom_range(0, 1);
            cmd_is_write = $urandom_range(0, 1);
            cmd_addr     = {$urandom, $urandom};
            cmd_wdata    = $urandom;
            ready        = ($urandom_range(0, 9) < 4);
            rdata        = $urandom;
            rsp_ready    = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
